dec_count_arb: RTL
==================

Name: dec_count_arb

Overview:
- Round-robin arbiter and sequencer that shares one mod-11 decade counter (counts 0..10, then wraps to 0) between two requesters.
- Grants the counter to one requester and clears it.
- Enables the counter until it reaches that requester's target value, then pulses done to the winner.
- Sits between client control logic and the shared counter. The counter exposes synchronous clear (cnt_clr) and count enable (cnt_en) and returns its value on count_in.

Parameters:
- WIDTH, 4, width of count_in and targets.
- MAXV, 10, terminal count of the shared counter; targets above MAXV saturate to MAXV.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req  in  2  per-requester job request; level, held until done or abandoned
- tgt0  in  WIDTH  target count for requester 0, sampled at grant
- tgt1  in  WIDTH  target count for requester 1, sampled at grant
- count_in  in  WIDTH  current value of the shared counter
- cnt_clr  out  1  synchronous clear to the counter
- cnt_en  out  1  count enable to the counter
- gnt  out  2  one-hot owner of the counter
- done  out  2  one-cycle completion pulse to the owner
- busy  out  1  high whenever state is not IDLE
- err  out  1  one-cycle timeout pulse (see Optional Feature)

Behaviour:
- Reset is asynchronous and active-low (reset=0): state=IDLE, rr pointer=0, tgt_q=0, gnt=00, done=00, cnt_clr=0, cnt_en=0, busy=0, err=0. All outputs are 0 while reset is held.
- FSM states are IDLE, CLEAR, RUN and DONE. State, gnt, tgt_q and the rr pointer are registered.
- IDLE:
  - If any req bit is set, select the owner. The pointer's requester has priority; otherwise take the other active requester.
  - Latch tgt_q = min(tgt_owner, MAXV).
  - Set gnt one-hot, set the pointer to the non-winner, go to CLEAR.
  - If req=00, stay in IDLE.
- CLEAR: cnt_clr=1 for exactly one cycle, cnt_en=0, then go to RUN.
- RUN:
  - cnt_en = (count_in != tgt_q), decoded combinationally so the counter never overshoots.
  - When count_in == tgt_q, go to DONE.
  - If tgt_q=0, RUN lasts one cycle with cnt_en=0.
- DONE: done[owner]=1 for one cycle, gnt still held, then go to IDLE with gnt=00.
- busy = (state != IDLE).
- Latency: gnt rises in the cycle after req is sampled. done is high exactly tgt_q+2 cycles after gnt first goes high (CLEAR 1 cycle, RUN tgt_q+1 cycles).
- Abandon: if req[owner] drops in CLEAR or RUN, cnt_en=0 immediately, go to IDLE next edge, gnt=00, and no done.
- req still high on return to IDLE is treated as a new job. Round-robin then grants the other requester first if it is requesting.
- Simultaneous requests (req=11) in IDLE: the pointer wins and the loser waits. This gives strict alternation under continuous load.
- The other requester's req and tgt are ignored while a job is in progress. The owner's tgt is ignored after it is latched.
- The controller never asserts cnt_clr and cnt_en in the same cycle.
- Reset asserted mid-job forces IDLE at once with no done pulse.

Optional Feature:
- Macro: DEC_COUNT_ARB_TIMEOUT_EN.
- Defined:
  - A RUN-cycle counter starts at 0 on entry to RUN.
  - If it reaches MAXV+2 without a match (counter stuck or wrapped past target), err pulses for one cycle.
  - cnt_en drops, gnt clears, state goes to IDLE, and no done is issued.
- Not defined: no timeout logic, err is tied to 0, and RUN waits indefinitely for a match.

Test Plan:
- Reset mid-RUN: req=01, tgt0=3, assert reset at count 2 -> all outputs 0 immediately; after release, state IDLE and pointer=0.
- Single job: req=01, tgt0=3, model counter -> gnt=01 next cycle; cnt_clr for 1 cycle; cnt_en for 3 cycles; done=01 exactly 5 cycles after gnt rises; busy drops after done.
- Zero/saturation: tgt1=0 -> done 2 cycles after gnt with cnt_en never high; tgt1=15 -> counts to 10 and done after 12 cycles.
- Contention: req=11 held, tgt0=2, tgt1=4 -> grants alternate 01,10,01,...; gnt is never 11; done goes to the matching owner each time.
- Abandon: req=10, tgt1=9, drop req[1] at count 4 -> cnt_en=0 the same cycle, gnt=00 next cycle, no done; a pending req[0] is granted next.
- Timeout (macro on): model counter ignores cnt_en and stays at 0, tgt0=5 -> err pulse after 12 RUN cycles, no done, state returns to IDLE. With the macro off, busy stays high and err=0.

Source files
------------

// File: rtl/dec_count_arb.sv
// Round-robin arbiter sharing one mod-(MAXV+1) counter between two requesters.
// Ports: clk, reset (async active-low), req[1:0], tgt0/tgt1, count_in
//        -> cnt_clr, cnt_en, gnt[1:0], done[1:0], busy, err.
// Optional run timeout: define DEC_COUNT_ARB_TIMEOUT_EN.
module dec_count_arb #(
  parameter int WIDTH = 4,
  parameter int MAXV  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] tgt0,
  input  logic [WIDTH-1:0] tgt1,
  input  logic [WIDTH-1:0] count_in,
  output logic             cnt_clr,
  output logic             cnt_en,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic             rr_q, rr_d;

  logic             own_req;
  logic             hit;
  logic             win;
  logic [WIDTH-1:0] tsel;
  logic             tmo;

  assign own_req = |(req & gnt_q);
  assign hit     = (count_in == tgt_q);
  // pointer's requester first, else the other one
  assign win     = req[rr_q] ? rr_q : ~rr_q;
  assign tsel    = win ? tgt1 : tgt0;

`ifdef DEC_COUNT_ARB_TIMEOUT_EN
  localparam int TW = $clog2(MAXV + 3);

  logic [TW-1:0] run_q, run_d;

  // run_q holds the number of RUN cycles already spent
  assign run_d = (state_q == RUN) ? run_q + 1'b1 : '0;
  assign tmo   = (run_q == TW'(MAXV + 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q <= '0;
    end else begin
      run_q <= run_d;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    tgt_d   = tgt_q;
    rr_d    = rr_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    done    = 2'b00;
    err     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d   = win ? 2'b10 : 2'b01;
          rr_d    = ~win;
          tgt_d   = (tsel > WIDTH'(MAXV)) ? WIDTH'(MAXV) : tsel;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        cnt_clr = 1'b1;
        if (!own_req) begin
          state_d = IDLE;
          gnt_d   = 2'b00;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!own_req) begin
          state_d = IDLE;
          gnt_d   = 2'b00;
        end else if (hit) begin
          state_d = DONE;
        end else if (tmo) begin
          err     = 1'b1;
          state_d = IDLE;
          gnt_d   = 2'b00;
        end else begin
          cnt_en = 1'b1;
        end
      end
      DONE: begin
        done    = gnt_q;
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      tgt_q   <= '0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      tgt_q   <= tgt_d;
      rr_q    <= rr_d;
    end
  end

  assign gnt  = gnt_q;
  assign busy = (state_q != IDLE);

endmodule
